imm_gen_pipe: RTL
=================

# imm_gen_pipe

Parametrised, pipelined RV32/RV64 immediate generator with valid/ready flow control. It decodes the opcode of each accepted instruction, assembles the sign-extended immediate for I/S/B/U/J formats, and flags illegal opcodes. It sits between instruction fetch and the ALU operand mux. It replaces the single-cycle combinational immediate generator once fetch and execute are decoupled.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- TAG_W, 5: width of the opaque sideband tag (e.g. rd index or ROB id) carried alongside each instruction.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous; clears all in-flight entries.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  raw instruction.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_imm  out  XLEN  sign-extended immediate, byte offset (B/J bit 0 = 0).
- out_type  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5.
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Transfer on the input side when in_valid && in_ready. Transfer on the output side when out_valid && out_ready.
- Stage 1 (S1) registers instr, tag, and the decoded type/illegal bits.
- Stage 2 (S2) registers the assembled immediate, type, illegal, and tag. out_* are driven straight from S2 registers.
- Opcode map (instr[6:0]):
  - I: 0000011, 0010011, 1100111, 1110011, and 0011011 (only when XLEN=64).
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - R: 0110011, and 0111011 (only when XLEN=64).
  - Anything else: type R, imm 0, illegal=1.
- Immediates:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U = sext({instr[31:12], 12'b0}); on XLEN=64, bits 63:32 replicate instr[31].
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R = 0.
- Sign extension is always from instr[31] to the full XLEN.
- Pipeline advance:
  - s2_adv = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_adv.
  - S1 moves to S2 when s1_valid && s2_adv.
- Data registers hold their value while stalled. Order is strictly FIFO.

## Timing
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 per cycle.
- Reset (rst_n=0 at a clock edge): s1_valid=0, s2_valid=0, out_imm=0, out_type=0, out_illegal=0, out_tag=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards both stages; nothing emerges.
- flush=1 at an edge clears s1_valid and s2_valid, and any same-cycle input transfer is dropped. Data registers need not clear.
- out_valid must not drop, and out_* must not change, while out_ready=0 (hold rule).
- With out_ready=0, the block absorbs exactly 2 instructions, then in_ready=0 until the next output transfer.
- in_ready depends combinationally on out_ready. in_valid/in_instr must not feed out_* combinationally.
- Simultaneous input and output transfer with both stages full: S2 takes S1 and S1 takes the new input; no bubble.

## Structure
- Package imm_gen_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_OP_IMM32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_OP32);
  - the 3-bit format encoding constants.
- One sub-module, imm_assemble: combinational function of (instr, type) returning the XLEN immediate. It sits between S1 and S2.

## Test plan
- XLEN=32, one at a time with out_ready=1:
  - 0x00700013 → imm 0x00000007, type I.
  - 0xFFF00013 → 0xFFFFFFFF, type I.
  - 0x00000323 → 0x00000006, type S.
  - 0x00000163 → 0x00000002, type B.
  - 0x80000063 → 0xFFFFF000, type B.
- 0x12345037 → 0x12345000 (U). 0x0080006F → 0x00000008 (J). 0x02000033 → imm 0, type R, illegal 0. 0x0000007F → imm 0, illegal 1.
- Backpressure: hold out_ready=0 and offer 3 back-to-back instructions.
  - Expect exactly 2 accepted and in_ready=0 from the third cycle on, with out_* stable.
  - Release out_ready: all 3 emerge in order with matching tags.
- Back-to-back stream of 16 random legal instructions with out_ready toggling pseudo-randomly → outputs match the reference model in order, with no loss or duplication.
- Pulse rst_n=0, then separately flush=1, while both stages are full → out_valid=0 on the next cycle and the old tags never appear; reset also zeroes out_imm.
- XLEN=64: 0xFFF00013 → 0xFFFFFFFFFFFFFFFF. 0x80000037 → 0xFFFFFFFF80000000. 0x0000001B (OP-IMM-32) → type I, illegal 0.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, format encoding and opcode decoder for the
// pipelined immediate generator.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    fmt_e fmt;
    logic illegal;
  } dec_t;

  // The *32 opcodes only exist on RV64; on RV32 they fall into the illegal bucket.
  function automatic dec_t decode_opcode(input logic [6:0] opc, input logic rv64);
    dec_t d;
    d.fmt     = FMT_R;
    d.illegal = 1'b0;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: d.fmt = FMT_I;
      OPC_OP_IMM32: begin
        d.fmt     = rv64 ? FMT_I : FMT_R;
        d.illegal = !rv64;
      end
      OPC_STORE:            d.fmt = FMT_S;
      OPC_BRANCH:           d.fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:   d.fmt = FMT_U;
      OPC_JAL:              d.fmt = FMT_J;
      OPC_OP:               d.fmt = FMT_R;
      OPC_OP32:             d.illegal = !rv64;
      default:              d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_assemble.sv
// Combinational immediate assembly: gathers the format's instruction bits
// into a 32-bit value, then sign-extends from instr[31] to XLEN.
module imm_assemble
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    // NOTE: default first so every path assigns raw and no latch is inferred.
    raw = '0;
    case (fmt)
      FMT_I:   raw = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   raw = {instr[31:12], 12'b0};
      FMT_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  // Every 32-bit pattern already carries instr[31] in bit 31, so a signed
  // widening cast gives the XLEN sign extension for free.
  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator with valid/ready flow control: S1 holds the
// raw instruction plus decode, S2 holds the assembled immediate and drives out_*.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic RV64 = (XLEN == 64);

  logic             s1_valid;
  logic [31:0]      s1_instr;
  logic [TAG_W-1:0] s1_tag;
  fmt_e             s1_fmt;
  logic             s1_illegal;
  logic [XLEN-1:0]  s1_imm;

  logic             s2_valid;
  logic [XLEN-1:0]  s2_imm;
  fmt_e             s2_fmt;
  logic             s2_illegal;
  logic [TAG_W-1:0] s2_tag;

  dec_t in_dec;
  logic s2_adv;
  logic s1_adv;
  logic in_fire;

  assign in_dec   = decode_opcode(in_instr[6:0], RV64);
  assign s2_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign s1_adv   = s1_valid && s2_adv;

  imm_assemble #(.XLEN(XLEN)) u_assemble (
    .instr (s1_instr),
    .fmt   (s1_fmt),
    .imm   (s1_imm)
  );

  // Flush shares the reset path for the valid bits; a same-cycle input is dropped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n || flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) s2_valid <= s1_valid;
      if (in_fire)     s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
    end
  end

  // NOTE: S1 payload is never observed without s1_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_instr   <= in_instr;
      s1_tag     <= in_tag;
      s1_fmt     <= in_dec.fmt;
      s1_illegal <= in_dec.illegal;
    end
  end

  // S2 payload drives the outputs directly, so it is reset to a clean zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_imm     <= '0;
      s2_fmt     <= FMT_R;
      s2_illegal <= 1'b0;
      s2_tag     <= '0;
    end else if (s1_adv) begin
      s2_imm     <= s1_imm;
      s2_fmt     <= s1_fmt;
      s2_illegal <= s1_illegal;
      s2_tag     <= s1_tag;
    end
  end

  assign out_valid   = s2_valid;
  assign out_imm     = s2_imm;
  assign out_type    = s2_fmt;
  assign out_illegal = s2_illegal;
  assign out_tag     = s2_tag;

endmodule
